// File: rtl/scr1_dmem_initiator.sv
// Data-memory initiator bridge: turns the core dmem request/response handshake
// into single-cycle strobes on a synchronous RAM port, with alignment/range checks.
module scr1_dmem_initiator #(
   parameter logic [31:0] MEM_SIZE   = 32'h0001_0000,
   parameter int unsigned RESP_DELAY = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dmem_req,
   input  logic                        dmem_cmd,
   input  logic [1:0]                  dmem_width,
   input  logic [31:0]                 dmem_addr,
   input  logic [31:0]                 dmem_wdata,
   output logic                        dmem_req_ack,
   output logic [31:0]                 dmem_rdata,
   output logic [1:0]                  dmem_resp,
   output logic                        mem_ren,
   output logic                        mem_wen,
   output logic [3:0]                  mem_web,
   output logic [$clog2(MEM_SIZE)-3:0] mem_addr,
   output logic [31:0]                 mem_wdata,
   input  logic [31:0]                 mem_rdata
);
   localparam int         AW         = $clog2(MEM_SIZE);
   localparam logic [3:0] DELAY_INIT = 4'(RESP_DELAY);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CAPT  = 2'd1,
      ST_DELAY = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   function automatic logic [3:0] lane_web(input logic [1:0] width, input logic [1:0] off);
      logic [3:0] web;
      case (width)
         2'd0:    web = 4'b0001 << off;
         2'd1:    web = 4'b0011 << off;
         default: web = 4'b1111;
      endcase
      return web;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] width, input logic [31:0] wdata);
      logic [31:0] data;
      case (width)
         2'd0:    data = {4{wdata[7:0]}};
         2'd1:    data = {2{wdata[15:0]}};
         default: data = wdata;
      endcase
      return data;
   endfunction

   // Right-justify the addressed lanes and zero everything above the access width.
   function automatic logic [31:0] extract_rdata(input logic [31:0] word, input logic [1:0] width,
                                                 input logic [1:0] off);
      logic [31:0] sh;
      logic [31:0] data;
      sh = word >> {off, 3'b000};
      case (width)
         2'd0:    data = {24'd0, sh[7:0]};
         2'd1:    data = {16'd0, sh[15:0]};
         default: data = sh;
      endcase
      return data;
   endfunction

   state_e      state_q, state_d;
   logic        cmd_q, cmd_d;
   logic [1:0]  width_q, width_d;
   logic [1:0]  off_q, off_d;
   logic        err_q, err_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  resp_q, resp_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic        align_err_s;
   logic        range_err_s;
   logic        req_err_s;
   logic        idle_s;
   logic        accept_s;

   // Alignment check per access width; width 3 is always illegal.
   always_comb begin
      align_err_s = 1'b0;
      case (dmem_width)
         2'd0:    align_err_s = 1'b0;
         2'd1:    align_err_s = dmem_addr[0];
         2'd2:    align_err_s = (dmem_addr[1:0] != 2'b00);
         default: align_err_s = 1'b1;
      endcase
   end

   assign range_err_s  = (dmem_addr >= MEM_SIZE);
   assign req_err_s    = align_err_s | range_err_s;
   assign idle_s       = (state_q == ST_IDLE) & ~rst;
   assign accept_s     = idle_s & dmem_req;

   assign dmem_req_ack = idle_s;
   assign dmem_resp    = resp_q;
   assign dmem_rdata   = resp_rdata_q;

   assign mem_ren      = accept_s & ~req_err_s & ~dmem_cmd;
   assign mem_wen      = accept_s & ~req_err_s & dmem_cmd;
   assign mem_web      = mem_wen ? lane_web(dmem_width, dmem_addr[1:0]) : 4'b0000;
   assign mem_addr     = dmem_addr[AW-1:2];
   assign mem_wdata    = lane_wdata(dmem_width, dmem_wdata);

   // Transaction sequencing; the response flops load on the edge entering RESP.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      width_d      = width_q;
      off_d        = off_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      resp_d       = 2'd0;
      resp_rdata_d = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               cmd_d   = dmem_cmd;
               width_d = dmem_width;
               off_d   = dmem_addr[1:0];
               err_d   = req_err_s;
               state_d = ST_CAPT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CAPT: begin
            if (!cmd_q && !err_q) begin
               rdata_d = extract_rdata(mem_rdata, width_q, off_q);
            end else begin
               rdata_d = 32'd0;
            end
            cnt_d = DELAY_INIT;
            if (DELAY_INIT != 4'd0) begin
               state_d = ST_DELAY;
            end else begin
               state_d      = ST_RESP;
               resp_d       = err_q ? 2'd2 : 2'd1;
               resp_rdata_d = rdata_d;
            end
         end
         ST_DELAY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d      = ST_RESP;
               resp_d       = err_q ? 2'd2 : 2'd1;
               resp_rdata_d = rdata_q;
            end else begin
               state_d = ST_DELAY;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cmd_q        <= 1'b0;
         width_q      <= 2'd0;
         off_q        <= 2'd0;
         err_q        <= 1'b0;
         cnt_q        <= 4'd0;
         rdata_q      <= 32'd0;
         resp_q       <= 2'd0;
         resp_rdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         width_q      <= width_d;
         off_q        <= off_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         resp_q       <= resp_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

endmodule

// File: tb/tb_scr1_dmem_initiator.sv
// Directed bench for scr1_dmem_initiator: one instance with no response delay,
// one with a delay of 3, each backed by a simple synchronous RAM model.
module tb_scr1_dmem_initiator;
   localparam logic [31:0] MEM_SIZE = 32'h0000_1000;

   logic        clk;
   logic        rst;
   logic        ram_clr;
   logic        req0, req3;
   logic        cmd;
   logic [1:0]  width;
   logic [31:0] addr, wdata;

   logic        ack0, ren0, wen0, ack3, ren3, wen3;
   logic [1:0]  resp0, resp3;
   logic [3:0]  web0, web3;
   logic [9:0]  maddr0, maddr3;
   logic [31:0] rdata0, rdata3, mwdata0, mwdata3, mrdata0, mrdata3;

   logic [31:0] ram0 [0:1023];
   logic [31:0] ram3 [0:1023];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        ack, ren, wen;
      logic [3:0]  web;
      logic [9:0]  maddr;
      logic [31:0] mwdata;
      logic [1:0]  resp0, resp1, resp2;
      logic [31:0] rdata2;
   } obs_t;

   scr1_dmem_initiator #(.MEM_SIZE(MEM_SIZE), .RESP_DELAY(0)) u0 (
      .clk(clk), .rst(rst), .dmem_req(req0), .dmem_cmd(cmd), .dmem_width(width),
      .dmem_addr(addr), .dmem_wdata(wdata), .dmem_req_ack(ack0), .dmem_rdata(rdata0),
      .dmem_resp(resp0), .mem_ren(ren0), .mem_wen(wen0), .mem_web(web0),
      .mem_addr(maddr0), .mem_wdata(mwdata0), .mem_rdata(mrdata0)
   );

   scr1_dmem_initiator #(.MEM_SIZE(MEM_SIZE), .RESP_DELAY(3)) u3 (
      .clk(clk), .rst(rst), .dmem_req(req3), .dmem_cmd(cmd), .dmem_width(width),
      .dmem_addr(addr), .dmem_wdata(wdata), .dmem_req_ack(ack3), .dmem_rdata(rdata3),
      .dmem_resp(resp3), .mem_ren(ren3), .mem_wen(wen3), .mem_web(web3),
      .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_rdata(mrdata3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous RAM models with byte write enables and registered read data.
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 1024; i++) begin
            ram0[i] <= 32'd0;
            ram3[i] <= 32'd0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (wen0 && web0[b]) ram0[maddr0][8*b +: 8] <= mwdata0[8*b +: 8];
            if (wen3 && web3[b]) ram3[maddr3][8*b +: 8] <= mwdata3[8*b +: 8];
         end
      end
      if (ren0) mrdata0 <= ram0[maddr0];
      if (ren3) mrdata3 <= ram3[maddr3];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   // One transaction on the zero-delay instance, starting just after a rising edge.
   task automatic run_txn0(input logic c, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] wd, output obs_t o);
      req0 = 1'b1; cmd = c; width = w; addr = a; wdata = wd;
      @(negedge clk);
      o.ack = ack0; o.ren = ren0; o.wen = wen0; o.web = web0;
      o.maddr = maddr0; o.mwdata = mwdata0; o.resp0 = resp0;
      @(posedge clk); #1;
      req0 = 1'b0;
      @(negedge clk);
      o.resp1 = resp0;
      @(posedge clk); #1;
      @(negedge clk);
      o.resp2 = resp0; o.rdata2 = rdata0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ram_clr = 1'b1; req0 = 1'b0; req3 = 1'b0;
      cmd = 1'b0; width = 2'd0; addr = 32'd0; wdata = 32'd0;
      repeat (2) @(negedge clk);
      total++;
      if ({ack0, ren0, wen0, web0, resp0, ack3, ren3, wen3, web3, resp3} !== 18'd0 ||
          rdata0 !== 32'd0 || rdata3 !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs got ack0=%b ren0=%b wen0=%b web0=%b resp0=%0d rdata0=%h ack3=%b resp3=%0d rdata3=%h exp all zero",
                  ack0, ren0, wen0, web0, resp0, rdata0, ack3, resp3, rdata3);
      end
      @(posedge clk); #1;
      rst = 1'b0; ram_clr = 1'b0;
      @(negedge clk);
      total++;
      if (ack0 !== 1'b1 || ack3 !== 1'b1 || resp0 !== 2'd0) begin
         bad++;
         $display("FAIL reset_release got ack0=%b ack3=%b resp0=%0d exp 1 1 0", ack0, ack3, resp0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      obs_t o;
      run_txn0(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, o);
      total++;
      if (o.ack !== 1'b1 || o.wen !== 1'b1 || o.ren !== 1'b0 || o.web !== 4'b1111 ||
          o.maddr !== 10'h040 || o.mwdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL word_wr_strobe got ack=%b wen=%b ren=%b web=%b maddr=%h wdata=%h exp 1 1 0 1111 040 deadbeef",
                  o.ack, o.wen, o.ren, o.web, o.maddr, o.mwdata);
      end
      total++;
      if (o.resp1 !== 2'd0 || o.resp2 !== 2'd1 || o.rdata2 !== 32'd0) begin
         bad++;
         $display("FAIL word_wr_resp got resp1=%0d resp2=%0d rdata=%h exp 0 1 0", o.resp1, o.resp2, o.rdata2);
      end
      run_txn0(1'b0, 2'd2, 32'h100, 32'd0, o);
      total++;
      if (o.ack !== 1'b1 || o.ren !== 1'b1 || o.wen !== 1'b0 || o.web !== 4'b0000) begin
         bad++;
         $display("FAIL word_rd_strobe got ack=%b ren=%b wen=%b web=%b exp 1 1 0 0000", o.ack, o.ren, o.wen, o.web);
      end
      total++;
      if (o.resp2 !== 2'd1 || o.rdata2 !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL word_rd_resp got resp=%0d rdata=%h exp 1 deadbeef", o.resp2, o.rdata2);
      end
   endtask

   task automatic test_lanes();
      obs_t o;
      logic        rc [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [1:0]  rw [5]  = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd0};
      logic [31:0] ra [5]  = '{32'h200, 32'h202, 32'h203, 32'h200, 32'h200};
      logic [31:0] rx [5]  = '{32'h11AA3344, 32'h000011AA, 32'h00000011, 32'h11AABEEF, 32'h000000EF};
      run_txn0(1'b1, 2'd2, 32'h200, 32'h11223344, o);
      run_txn0(1'b1, 2'd0, 32'h202, 32'h000000AA, o);
      total++;
      if (o.web !== 4'b0100 || o.mwdata !== 32'hAAAAAAAA || o.maddr !== 10'h080 || o.resp2 !== 2'd1) begin
         bad++;
         $display("FAIL byte_wr got web=%b wdata=%h maddr=%h resp=%0d exp 0100 aaaaaaaa 080 1",
                  o.web, o.mwdata, o.maddr, o.resp2);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 3) begin
            run_txn0(1'b1, 2'd1, 32'h200, 32'h1234BEEF, o);
            total++;
            if (o.web !== 4'b0011 || o.mwdata !== 32'hBEEFBEEF) begin
               bad++;
               $display("FAIL half_wr got web=%b wdata=%h exp 0011 beefbeef", o.web, o.mwdata);
            end
         end
         run_txn0(rc[i], rw[i], ra[i], 32'd0, o);
         total++;
         if (o.ren !== 1'b1 || o.resp2 !== 2'd1 || o.rdata2 !== rx[i]) begin
            bad++;
            $display("FAIL lane_rd[%0d] got ren=%b resp=%0d rdata=%h exp 1 1 %h", i, o.ren, o.resp2, o.rdata2, rx[i]);
         end
      end
   endtask

   task automatic test_errors();
      obs_t o;
      logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0]  ew [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
      logic [31:0] ea [4] = '{32'h101, 32'h102, 32'h100, 32'h1000};
      for (int i = 0; i < 4; i++) begin
         run_txn0(ec[i], ew[i], ea[i], 32'h55AA55AA, o);
         total++;
         if (o.ack !== 1'b1 || o.ren !== 1'b0 || o.wen !== 1'b0 || o.web !== 4'b0000) begin
            bad++;
            $display("FAIL err_strobe[%0d] got ack=%b ren=%b wen=%b web=%b exp 1 0 0 0000", i, o.ack, o.ren, o.wen, o.web);
         end
         total++;
         if (o.resp1 !== 2'd0 || o.resp2 !== 2'd2 || o.rdata2 !== 32'd0) begin
            bad++;
            $display("FAIL err_resp[%0d] got resp1=%0d resp2=%0d rdata=%h exp 0 2 0", i, o.resp1, o.resp2, o.rdata2);
         end
      end
   endtask

   task automatic test_delay();
      req3 = 1'b1; cmd = 1'b1; width = 2'd2; addr = 32'h300; wdata = 32'hCAFEF00D;
      @(negedge clk);
      total++;
      if (ack3 !== 1'b1 || wen3 !== 1'b1 || web3 !== 4'b1111) begin
         bad++;
         $display("FAIL dly_wr_accept got ack=%b wen=%b web=%b exp 1 1 1111", ack3, wen3, web3);
      end
      @(posedge clk); #1;
      cmd = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         total++;
         if (ack3 !== 1'b0 || ren3 !== 1'b0 || wen3 !== 1'b0 ||
             resp3 !== ((k == 5) ? 2'd1 : 2'd0) || rdata3 !== 32'd0) begin
            bad++;
            $display("FAIL dly_wr_busy[T+%0d] got ack=%b ren=%b wen=%b resp=%0d rdata=%h exp 0 0 0 %0d 0",
                     k, ack3, ren3, wen3, resp3, rdata3, (k == 5) ? 1 : 0);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if (ack3 !== 1'b1 || ren3 !== 1'b1 || maddr3 !== 10'h0C0) begin
         bad++;
         $display("FAIL dly_rd_accept got ack=%b ren=%b maddr=%h exp 1 1 0c0", ack3, ren3, maddr3);
      end
      @(posedge clk); #1;
      req3 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         total++;
         if (ack3 !== 1'b0 || resp3 !== ((k == 5) ? 2'd1 : 2'd0) ||
             rdata3 !== ((k == 5) ? 32'hCAFEF00D : 32'd0)) begin
            bad++;
            $display("FAIL dly_rd_resp[T+%0d] got ack=%b resp=%0d rdata=%h", k, ack3, resp3, rdata3);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      req0 = 1'b1; cmd = 1'b0; width = 2'd2; addr = 32'h100;
      @(negedge clk);
      total++;
      if (ack0 !== 1'b1 || ren0 !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_accept got ack=%b ren=%b exp 1 1", ack0, ren0);
      end
      @(posedge clk); #1;
      req0 = 1'b0; rst = 1'b1;
      #1;
      total++;
      if ({ack0, ren0, wen0, web0, resp0} !== 9'd0 || rdata0 !== 32'd0) begin
         bad++;
         $display("FAIL rstmid_outputs got ack=%b ren=%b wen=%b web=%b resp=%0d rdata=%h exp all zero",
                  ack0, ren0, wen0, web0, resp0, rdata0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_txn0(1'b0, 2'd2, 32'h100, 32'd0, o);
      total++;
      if (o.ack !== 1'b1 || o.resp0 !== 2'd0 || o.resp1 !== 2'd0) begin
         bad++;
         $display("FAIL rstmid_dropped got ack=%b resp_t2=%0d resp_t3=%0d exp 1 0 0", o.ack, o.resp0, o.resp1);
      end
      total++;
      if (o.resp2 !== 2'd1 || o.rdata2 !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL rstmid_next_read got resp=%0d rdata=%h exp 1 deadbeef", o.resp2, o.rdata2);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  em [0:63];
      logic        c  [16];
      logic [1:0]  w  [16];
      logic [5:0]  off[16];
      logic [31:0] d  [16];
      logic [31:0] exp_rd;
      logic [3:0]  exp_web;
      int          n;
      for (int i = 0; i < 64; i++) em[i] = 8'd0;
      for (int i = 0; i < 16; i++) begin
         c[i]   = 1'($urandom_range(0, 1));
         w[i]   = 2'($urandom_range(0, 2));
         off[i] = 6'($urandom_range(0, 63));
         if (w[i] == 2'd1) off[i][0]   = 1'b0;
         if (w[i] == 2'd2) off[i][1:0] = 2'b00;
         d[i]   = $urandom;
      end
      req0 = 1'b1; cmd = c[0]; width = w[0]; addr = 32'h400 + {26'd0, off[0]}; wdata = d[0];
      for (int i = 0; i < 16; i++) begin
         n = (w[i] == 2'd0) ? 1 : ((w[i] == 2'd1) ? 2 : 4);
         exp_web = 4'(((1 << n) - 1) << off[i][1:0]);
         exp_rd  = 32'd0;
         for (int k = 0; k < n; k++) begin
            if (c[i]) em[off[i] + 6'(k)] = d[i][8*k +: 8];
            else      exp_rd[8*k +: 8] = em[off[i] + 6'(k)];
         end
         @(negedge clk);
         total++;
         if (ack0 !== 1'b1 || ren0 !== !c[i] || wen0 !== c[i] || web0 !== (c[i] ? exp_web : 4'b0000)) begin
            bad++;
            $display("FAIL b2b_accept[%0d] got ack=%b ren=%b wen=%b web=%b exp 1 %b %b %b",
                     i, ack0, ren0, wen0, web0, !c[i], c[i], c[i] ? exp_web : 4'b0000);
         end
         @(posedge clk); #1;
         if (i < 15) begin
            cmd = c[i+1]; width = w[i+1]; addr = 32'h400 + {26'd0, off[i+1]}; wdata = d[i+1];
         end else begin
            req0 = 1'b0;
         end
         @(negedge clk);
         total++;
         if (ack0 !== 1'b0 || ren0 !== 1'b0 || wen0 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy[%0d] got ack=%b ren=%b wen=%b exp 0 0 0", i, ack0, ren0, wen0);
         end
         @(posedge clk); #1;
         @(negedge clk);
         total++;
         if (ack0 !== 1'b0 || resp0 !== 2'd1 || rdata0 !== exp_rd) begin
            bad++;
            $display("FAIL b2b_resp[%0d] got ack=%b resp=%0d rdata=%h exp 0 1 %h", i, ack0, resp0, rdata0, exp_rd);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_lanes();
      test_errors();
      test_delay();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scr1_dmem_initiator.md
# scr1_dmem_initiator

Initiator-side bridge that turns a core-style data-memory request/response handshake into the single-cycle strobes of a synchronous dual-port RAM's read/write port (port B). It accepts one request at a time and checks alignment and range. It generates byte enables and replicates write data, captures read data one cycle after the strobe, and returns a right-justified, zero-extended response after a programmable delay. It sits between the core's dmem interface and the TCM/RAM port B.

## Interface
- MEM_SIZE, 32'h00010000, RAM size in bytes; power of two, at least 8; AW = $clog2(MEM_SIZE)
- RESP_DELAY, 0, extra wait cycles before response, 0..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- dmem_req  in  1  request valid
- dmem_cmd  in  1  0 = read, 1 = write
- dmem_width  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- dmem_addr  in  32  byte address
- dmem_wdata  in  32  write data, right-justified
- dmem_req_ack  out  1  request accepted this cycle
- dmem_rdata  out  32  read data, right-justified, zero-extended
- dmem_resp  out  2  0 = idle, 1 = okay, 2 = error
- mem_ren  out  1  RAM read strobe
- mem_wen  out  1  RAM write strobe
- mem_web  out  4  RAM byte write enables
- mem_addr  out  AW-2  RAM word address (dmem_addr[AW-1:2])
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM registered read data, valid the cycle after mem_ren

## Operation
- FSM states: IDLE, CAPT, DELAY, RESP.
- IDLE:
  - dmem_req_ack = 1.
  - When dmem_req = 1, the request is accepted. Go to CAPT.
  - Latch cmd, width, addr[1:0] and the error flag.
- Error flag is set for any of:
  - width = 3
  - halfword with addr[0] = 1
  - word with addr[1:0] != 0
  - addr >= MEM_SIZE
- Memory strobes (combinational, only in the accept cycle, only if no error):
  - Read: mem_ren = 1.
  - Write: mem_wen = 1; mem_web = 4'b0001 << addr[1:0] (byte), 4'b0011 << addr[1:0] (halfword), 4'b1111 (word).
  - mem_wdata: {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for halfword, wdata for word.
  - In all other cycles: mem_ren, mem_wen and mem_web are 0. mem_addr and mem_wdata are don't-care.
- CAPT:
  - For a non-error read, rdata_q <= (mem_rdata >> 8*addr[1:0]) masked to width. Otherwise rdata_q <= 0.
  - Load delay counter with RESP_DELAY.
  - Go to DELAY if RESP_DELAY > 0, else RESP.
- DELAY: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP:
  - dmem_resp = 2 if error, else 1. dmem_rdata = rdata_q; writes return 0.
  - Next state is IDLE.
- Outside RESP: dmem_resp = 0 and dmem_rdata = 0.
- dmem_req_ack = 0 in CAPT, DELAY and RESP. The core must hold its request until it is acked.
- Error requests follow identical timing, with no RAM access.

## Timing
- Request accepted in cycle T → dmem_resp valid for exactly one cycle at T+2+RESP_DELAY.
- Next accept is possible at T+3+RESP_DELAY. Throughput is one transaction per 3+RESP_DELAY cycles.
- All outputs are 0 while rst is asserted: req_ack and the memory strobes are gated by ~rst; state goes to IDLE, counter and rdata_q to 0.
- Reset mid-transaction: the response is dropped and no resp is emitted. A write already strobed in its accept cycle remains in RAM.
- After rst deasserts, the first cycle is IDLE with req_ack = 1.
- A dmem_req asserted in a non-IDLE state is ignored. No state is captured and no strobe is issued.

## Test plan
- Word write then read, RESP_DELAY=0:
  - write 0x100 ← 0xDEADBEEF → mem_wen=1, mem_web=1111, mem_addr=0x40, resp=1 at T+2.
  - read 0x100 → mem_ren=1 at accept; rdata=0xDEADBEEF, resp=1 at T+2.
- Byte/halfword lanes, over word 0x200 = 0x11223344:
  - byte write 0xAA to 0x202 → web=0100, mem_wdata=0xAAAAAAAA.
  - word read → 0x11AA3344.
  - halfword read at 0x202 → rdata=0x000011AA.
  - byte read at 0x203 → 0x00000011.
- Misalignment/range/illegal width:
  - halfword at 0x101, word at 0x102, width=3, and addr=MEM_SIZE each → no strobes, resp=2, rdata=0 at T+2.
- RESP_DELAY=3:
  - read accepted at T → resp at T+5.
  - req_ack = 0 for T+1..T+5.
  - req held through T+1..T+5 → accepted at T+6.
- Reset mid-operation:
  - assert rst at T+1 of a read → all outputs 0 immediately; no resp ever emitted.
  - req_ack=1 in the first cycle after release; the following read completes normally.
- Back-to-back stream: 16 random legal reads and writes with dmem_req held high.
  - Exactly one ack per 3+RESP_DELAY cycles.
  - Scoreboard matches a byte-array model.
